// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state type and
// the five state encodings used by seq_pattern_tx.
package seq_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'b000;
  localparam state_t ST_LOAD  = 3'b001;
  localparam state_t ST_SHIFT = 3'b011;
  localparam state_t ST_GAP   = 3'b010;
  localparam state_t ST_DONE  = 3'b110;

endpackage

// File: rtl/seq_tx_shreg.sv
// Frame holder for seq_pattern_tx: keeps the latched pattern and length,
// walks a bit index through the frame and flags the final bit.
module seq_tx_shreg #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               restart,
  input  logic               advance,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               serial_bit,
  output logic               last_bit
);

  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   length_r;
  logic [IDX_W-1:0]   idx_r;

  // Capture a new frame on load; otherwise rewind or step the bit index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_r <= {MAX_LEN{1'b0}};
      length_r  <= {LEN_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
    end else if (load) begin
      pattern_r <= pattern;
      length_r  <= length;
      idx_r     <= {IDX_W{1'b0}};
    end else if (restart) begin
      idx_r     <= {IDX_W{1'b0}};
    end else if (advance) begin
      idx_r     <= idx_r + IDX_W'(1);
    end else begin
      idx_r     <= idx_r;
    end
  end

  // length_r is never below 1 while a frame is active, so length-1 fits IDX_W.
  assign serial_bit = pattern_r[idx_r];
  assign last_bit   = (idx_r == IDX_W'(length_r - LEN_W'(1)));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: loads a frame in parallel and shifts it out
// LSB-first, repeating it repeat_count extra times with GAP_CYCLES idle
// cycles between frames. All outputs decode from registered state.
// Optional feature: define SEQ_TX_ABORT_EN to add the `abort` input.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int CW         = 6,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [CW-1:0]      repeat_count,
`ifdef SEQ_TX_ABORT_EN
  input  logic               abort,
`endif
  output logic               serial_output,
  output logic               valid_output,
  output logic               busy,
  output logic               done,
  output logic [2:0]         current_state,
  output logic [CW-1:0]      frame_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t          state_r, state_s;
  logic [CW-1:0]   rep_r, rep_s;
  logic [GW-1:0]   gap_r, gap_s;
  logic [CW-1:0]   fcnt_r, fcnt_s;
  logic            load_s, restart_s, advance_s;
  logic            abort_s;
  logic            bit_s, last_bit_s;
  logic [LEN_W-1:0] length_clamp_s;

`ifdef SEQ_TX_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign length_clamp_s = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;

  seq_tx_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .restart    (restart_s),
    .advance    (advance_s),
    .pattern    (pattern),
    .length     (length_clamp_s),
    .serial_bit (bit_s),
    .last_bit   (last_bit_s)
  );

  // Next-state logic for the FSM, repeat/gap counters and frame counter.
  always_comb begin
    state_s   = state_r;
    rep_s     = rep_r;
    gap_s     = gap_r;
    fcnt_s    = fcnt_r;
    load_s    = 1'b0;
    restart_s = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (length != {LEN_W{1'b0}})) begin
          state_s = ST_LOAD;
          load_s  = 1'b1;
          rep_s   = repeat_count;
          fcnt_s  = {CW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s   = ST_SHIFT;
          restart_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else if (last_bit_s) begin
          fcnt_s = (fcnt_r == {CW{1'b1}}) ? fcnt_r : fcnt_r + CW'(1);
          if (rep_r != {CW{1'b0}}) begin
            rep_s = rep_r - CW'(1);
            if (GAP_CYCLES == 0) begin
              state_s   = ST_SHIFT;
              restart_s = 1'b1;
            end else begin
              state_s = ST_GAP;
              gap_s   = GW'(GAP_CYCLES - 1);
            end
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          advance_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort_s) begin
          state_s = ST_IDLE;
        end else if (gap_r == {GW{1'b0}}) begin
          state_s   = ST_SHIFT;
          restart_s = 1'b1;
        end else begin
          gap_s = gap_r - GW'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      rep_r   <= {CW{1'b0}};
      gap_r   <= {GW{1'b0}};
      fcnt_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      rep_r   <= rep_s;
      gap_r   <= gap_s;
      fcnt_r  <= fcnt_s;
    end
  end

  assign valid_output  = (state_r == ST_SHIFT);
  assign serial_output = valid_output & bit_s;
  assign busy          = (state_r != ST_IDLE);
  assign done          = (state_r == ST_DONE);
  assign current_state = state_r;
  assign frame_count   = fcnt_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed, table-driven bench for seq_pattern_tx (MAX_LEN=16, GAP_CYCLES=1).
module tb_seq_pattern_tx;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [5:0]  repeat_count;
  logic        abort;
  logic        serial_output;
  logic        valid_output;
  logic        busy;
  logic        done;
  logic [2:0]  current_state;
  logic [5:0]  frame_count;

  int tests_run = 0;
  int tests_failed = 0;

  seq_pattern_tx #(
    .MAX_LEN    (16),
    .CW         (6),
    .GAP_CYCLES (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .pattern       (pattern),
    .length        (length),
    .repeat_count  (repeat_count),
`ifdef SEQ_TX_ABORT_EN
    .abort         (abort),
`endif
    .serial_output (serial_output),
    .valid_output  (valid_output),
    .busy          (busy),
    .done          (done),
    .current_state (current_state),
    .frame_count   (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pattern;
    logic [4:0]  length;
    logic [5:0]  rep;
    logic        glitch;
    int          done_cyc;
    logic [63:0] exp_valid;
    logic [63:0] exp_serial;
    logic [5:0]  exp_fcnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one transfer starting from an IDLE cycle and ends in the IDLE cycle after DONE.
  task automatic run_vec(input int v);
    logic [2:0] exp_st;
    pattern      = vecs[v].pattern;
    length       = vecs[v].length;
    repeat_count = vecs[v].rep;
    start        = 1'b1;
    step();
    start = 1'b0;
    check($sformatf("v%0d c0 state", v), current_state, 3'b001);
    check($sformatf("v%0d c0 busy", v), busy, 1'b1);
    check($sformatf("v%0d c0 valid", v), valid_output, 1'b0);
    for (int c = 1; c <= vecs[v].done_cyc; c++) begin
      step();
      if (c == vecs[v].done_cyc) exp_st = 3'b110;
      else if (vecs[v].exp_valid[c]) exp_st = 3'b011;
      else exp_st = 3'b010;
      check($sformatf("v%0d c%0d state", v, c), current_state, exp_st);
      check($sformatf("v%0d c%0d valid", v, c), valid_output, vecs[v].exp_valid[c]);
      check($sformatf("v%0d c%0d serial", v, c), serial_output, vecs[v].exp_serial[c]);
      check($sformatf("v%0d c%0d done", v, c), done, (c == vecs[v].done_cyc) ? 1'b1 : 1'b0);
      check($sformatf("v%0d c%0d busy", v, c), busy, 1'b1);
      if (vecs[v].glitch && c == 2) begin
        start        = 1'b1;
        pattern      = 16'hFFF6;
        length       = 5'd4;
        repeat_count = 6'd3;
      end else if (vecs[v].glitch && c == 3) begin
        start = 1'b0;
      end
    end
    check($sformatf("v%0d frame_count at done", v), frame_count, vecs[v].exp_fcnt);
    step();
    check($sformatf("v%0d idle state", v), current_state, 3'b000);
    check($sformatf("v%0d idle busy", v), busy, 1'b0);
    check($sformatf("v%0d idle done", v), done, 1'b0);
    check($sformatf("v%0d idle frame_count", v), frame_count, vecs[v].exp_fcnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " serial"}, serial_output, 1'b0);
    check({tag, " valid"}, valid_output, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " state"}, current_state, 3'b000);
    check({tag, " frame_count"}, frame_count, 6'd0);
  endtask

  initial begin
    //         pattern   len    rep  glitch done  exp_valid      exp_serial     fcnt
    vecs[0] = '{16'h0007, 5'd3,  6'd0, 1'b0, 4,  64'h000E,      64'h000E,      6'd1};
    vecs[1] = '{16'h0006, 5'd4,  6'd2, 1'b0, 15, 64'h7BDE,      64'h318C,      6'd3};
    vecs[2] = '{16'hA5C3, 5'd20, 6'd0, 1'b0, 17, 64'h1FFFE,     64'h14B86,     6'd1};
    vecs[3] = '{16'h0005, 5'd3,  6'd1, 1'b0, 8,  64'h00EE,      64'h00AA,      6'd2};
    vecs[4] = '{16'h0002, 5'd2,  6'd0, 1'b0, 3,  64'h0006,      64'h0004,      6'd1};
    vecs[5] = '{16'h0001, 5'd1,  6'd3, 1'b0, 8,  64'h00AA,      64'h00AA,      6'd4};
    vecs[6] = '{16'h0009, 5'd4,  6'd0, 1'b1, 5,  64'h001E,      64'h0012,      6'd1};

    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern = 16'h0000;
    length = 5'd0;
    repeat_count = 6'd0;
    #12;
    check_reset_vals("por");
    @(negedge clock);
    reset = 1'b1;
    step();
    check_reset_vals("after release");

    for (int v = 0; v < 7; v++) begin
      run_vec(v);
    end

    // length=0 request is ignored and leaves frame_count alone
    pattern = 16'hFFFF;
    length = 5'd0;
    start = 1'b1;
    step();
    check("len0 state", current_state, 3'b000);
    check("len0 busy", busy, 1'b0);
    check("len0 frame_count", frame_count, vecs[6].exp_fcnt);
    step();
    check("len0 state later", current_state, 3'b000);
    start = 1'b0;

    // asynchronous reset in the middle of the second frame
    pattern = 16'h0003;
    length = 5'd2;
    repeat_count = 6'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    check("rst pre state", current_state, 3'b011);
    check("rst pre serial", serial_output, 1'b1);
    check("rst pre frame_count", frame_count, 6'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async rst");
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rst hold done %0d", c), done, 1'b0);
      check($sformatf("rst hold busy %0d", c), busy, 1'b0);
    end
    #2;
    reset = 1'b1;
    step();
    check_reset_vals("rst released");
    run_vec(0);

`ifdef SEQ_TX_ABORT_EN
    // abort during the second frame: back to IDLE, no done, frame_count held
    pattern = 16'h000F;
    length = 5'd4;
    repeat_count = 6'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) step();
    check("abort pre state", current_state, 3'b011);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort state", current_state, 3'b000);
    check("abort busy", busy, 1'b0);
    check("abort valid", valid_output, 1'b0);
    check("abort done", done, 1'b0);
    check("abort frame_count", frame_count, 6'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("abort later done %0d", c), done, 1'b0);
    end
    run_vec(4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives test and stimulus bit sequences onto a single-bit line, one bit per clock. It is the transmit end of the serial sequence link and feeds a sequence-detector FSM in place of hand-written input stimulus. A frame is loaded in parallel, shifted out LSB-first, and can repeat a programmable number of times with idle gap cycles between repeats.

## Interface
- MAX_LEN, 16, maximum frame length in bits; must be at least 2.
- LEN_W, $clog2(MAX_LEN+1), width of `length`.
- CW, 6, width of `repeat_count` and `frame_count`.
- GAP_CYCLES, 1, idle cycles between repeated frames; 0 means back-to-back frames.

- clock  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to send; sampled only in IDLE.
- pattern  in  MAX_LEN  frame bits; bit 0 is sent first.
- length  in  LEN_W  number of bits per frame.
- repeat_count  in  CW  extra repeats; N sends N+1 frames.
- serial_output  out  1  current serial bit; 0 when not valid.
- valid_output  out  1  high while `serial_output` carries a frame bit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last bit of the last frame.
- current_state  out  3  FSM state, for debug.
- frame_count  out  CW  frames completed since the last accepted start; saturates at all-ones.

## Operation
- State encoding: IDLE=000, LOAD=001, SHIFT=011, GAP=010, DONE=110. The remaining codes go to IDLE.
- IDLE:
  - If `start`=1 and `length`≠0, go to LOAD.
  - In that case, latch `pattern`, `min(length, MAX_LEN)` and `repeat_count`, and clear `frame_count`.
  - If `start`=1 and `length`=0, ignore the request and stay in IDLE.
- LOAD: lasts one cycle and always goes to SHIFT. Bit index clears to 0.
- SHIFT:
  - `serial_output` = latched pattern[idx]; `valid_output`=1.
  - When idx is not yet length-1, idx increments each cycle.
  - At idx = length-1:
    - `frame_count` increments, saturating at all-ones.
    - If repeats remain, decrement the repeat counter and go to GAP. If GAP_CYCLES=0, go to SHIFT with idx=0 instead.
    - If no repeats remain, go to DONE.
- GAP: lasts GAP_CYCLES cycles with `serial_output`=0 and `valid_output`=0, then goes to SHIFT with idx=0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in every state except IDLE. The latched inputs stay frozen while `busy`=1.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.

## Timing
- Reset values: state IDLE, `serial_output`=0, `valid_output`=0, `busy`=0, `done`=0, `current_state`=000, `frame_count`=0.
- Cycle numbering: cycle n is the cycle after rising edge n, where edge 0 samples `start`=1.
  - Cycle 0: LOAD, `busy`=1.
  - Bit i of frame k is in cycle 1 + k·(L+GAP_CYCLES) + i.
  - `done` is in the cycle after the final bit.
  - Single frame of length L: `done` in cycle L+1.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock edge. No `done` pulse is produced.
- A new `start` can be accepted at the earliest in the first IDLE cycle after DONE.

## Configuration
- SEQ_TX_ABORT_EN defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 at a rising edge in LOAD, SHIFT or GAP moves the FSM to IDLE at the next cycle.
  - The abort produces no `done` pulse. `valid_output` drops and `frame_count` holds its value.
  - `abort` has no effect in IDLE or DONE.
- SEQ_TX_ABORT_EN undefined: no `abort` port, and a frame sequence always runs to DONE.

## Structure
- Package `seq_tx_pkg` holds:
  - the five state encoding constants;
  - the 3-bit state typedef.
- One sub-module, `seq_tx_shreg`, holds:
  - the latched pattern and the bit index, with load and advance controls;
  - the `last_bit` flag.
- The FSM, the repeat counter, the gap counter and `frame_count` stay in the top level.

## Test plan
- pattern=16'h0007, length=3, repeat=0, start at edge 0 -> `serial_output` = 1,1,1 in cycles 1–3 with `valid_output`=1, `done`=1 in cycle 4, `frame_count`=1.
- pattern=16'h0006, length=4, repeat=2, GAP_CYCLES=1 -> bits 0,1,1,0 in cycles 1–4, 6–9 and 11–14, with gap cycles 5 and 10 showing `valid_output`=0; `done` in cycle 15; `frame_count`=3.
- length=0 with start=1 -> stays IDLE, `busy`=0, `frame_count` unchanged. Then length=20 with MAX_LEN=16 -> exactly 16 bits are sent.
- start pulsed again in cycle 2 of a transfer, with a different pattern -> ignored; the original bits complete unchanged.
- reset driven low mid-SHIFT, between clock edges -> all outputs reach reset values immediately, with no `done` pulse. After release, a fresh start transmits normally.
- SEQ_TX_ABORT_EN defined, abort=1 at the edge into cycle 3 of a 4-bit frame -> IDLE in cycle 3, no `done` pulse, `frame_count` held.
